// File: rtl/wb_fwd_pipe_pkg.sv
// -----------------------------------------------------------------------------
// wb_fwd_pkg
// Shared encodings for the write-back select / forwarding pipeline:
//   - destination-register select codes presented by the D stage
//   - forwarding-source codes reported per read port
//   - reference stage record {valid, wa, tnew, data} at the core's default widths
// -----------------------------------------------------------------------------
package wb_fwd_pkg;

    // Destination select at D
    typedef enum logic [1:0] {
        WA_RT   = 2'd0,
        WA_RD   = 2'd1,
        WA_RA   = 2'd2,
        WA_NONE = 2'd3
    } wa_sel_e;

    // Forwarding source per read port
    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_sel_e;

    // Core default widths
    localparam int DEF_DW  = 32;
    localparam int DEF_AW  = 5;
    localparam int DEF_TNW = 2;

    // Link register number used by jal / jalr
    localparam int RA_NUM  = 31;

    // One in-flight producer as carried through E/M/W (default widths)
    typedef struct packed {
        logic                valid;
        logic [DEF_AW-1:0]   wa;
        logic [DEF_TNW-1:0]  tnew;
        logic [DEF_DW-1:0]   data;
    } stage_t;

endpackage : wb_fwd_pkg

// File: rtl/wb_fwd_pipe_if.sv
// -----------------------------------------------------------------------------
// wb_fwd_pipe_if
// Bundles the D-stage producer description, stage results, D read ports and
// the GRF write port of the forwarding pipeline.
//   master : the core side (drives instruction info, results, read addresses)
//   slave  : wb_fwd_pipe (returns forwarded operands, stall, GRF write port)
// -----------------------------------------------------------------------------
interface wb_fwd_pipe_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2,
    parameter int TNW = 2
);
    logic                 id_valid;
    logic [1:0]           id_wa_sel;
    logic [AW-1:0]        id_rt;
    logic [AW-1:0]        id_rd;
    logic [TNW-1:0]       id_tnew;
    logic [DW-1:0]        id_data;
    logic [DW-1:0]        e_res;
    logic [DW-1:0]        m_res;
    logic                 flush_e;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD-1:0]       rd_en;
    logic [NRD*DW-1:0]    grf_rdata;
    logic [NRD*DW-1:0]    fwd_data;
    logic [NRD*2-1:0]     fwd_sel;
    logic                 stall;
    logic                 grf_we;
    logic [AW-1:0]        grf_wa;
    logic [DW-1:0]        grf_wd;

    modport master (
        output id_valid, id_wa_sel, id_rt, id_rd, id_tnew, id_data,
        output e_res, m_res, flush_e, rd_addr, rd_en, grf_rdata,
        input  fwd_data, fwd_sel, stall, grf_we, grf_wa, grf_wd
    );

    modport slave (
        input  id_valid, id_wa_sel, id_rt, id_rd, id_tnew, id_data,
        input  e_res, m_res, flush_e, rd_addr, rd_en, grf_rdata,
        output fwd_data, fwd_sel, stall, grf_we, grf_wa, grf_wd
    );
endinterface : wb_fwd_pipe_if

// File: rtl/wb_fwd_pipe_chk.sv
// -----------------------------------------------------------------------------
// wb_fwd_pipe_chk
// Protocol checks for wb_fwd_pipe.
//   clk, reset : pipeline clock and synchronous reset
//   m_tnew     : tnew of the producer currently in M
// A producer in M may still be waiting for at most its own M-stage result.
// -----------------------------------------------------------------------------
module wb_fwd_pipe_chk #(
    parameter int TNW = 2
) (
    input logic           clk,
    input logic           reset,
    input logic [TNW-1:0] m_tnew
);

    // Producer latency beyond the M stage is not supported
    a_m_tnew_le1: assert property (@(posedge clk) disable iff (reset)
        m_tnew <= {{(TNW-1){1'b0}}, 1'b1});

endmodule : wb_fwd_pipe_chk

// File: rtl/wb_fwd_pipe_stage.sv
// -----------------------------------------------------------------------------
// wb_stage_reg
// One pipeline stage register holding {valid, wa, tnew, data}.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bubble     : load an empty producer instead of the input
//   in_*       : producer record from the previous stage
//   res        : result computed in the previous stage this cycle
//   q_*        : registered producer record
// With RESOLVE set, a producer whose tnew was non-zero takes its value from
// res and its tnew counts down by one; otherwise the record passes unchanged
// (used for E, which loads straight from D).
// -----------------------------------------------------------------------------
module wb_stage_reg #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int TNW     = 2,
    parameter bit RESOLVE = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           bubble,
    input  logic           in_valid,
    input  logic [AW-1:0]  in_wa,
    input  logic [TNW-1:0] in_tnew,
    input  logic [DW-1:0]  in_data,
    input  logic [DW-1:0]  res,
    output logic           q_valid,
    output logic [AW-1:0]  q_wa,
    output logic [TNW-1:0] q_tnew,
    output logic [DW-1:0]  q_data
);

    logic [TNW-1:0] nxt_tnew_s;
    logic [DW-1:0]  nxt_data_s;

    // Resolve data source and count tnew down when the result arrives here
    always_comb begin
        nxt_tnew_s = in_tnew;
        nxt_data_s = in_data;
        if (RESOLVE && (in_tnew != {TNW{1'b0}})) begin
            nxt_tnew_s = in_tnew - {{(TNW-1){1'b0}}, 1'b1};
            nxt_data_s = res;
        end else begin
            nxt_tnew_s = in_tnew;
            nxt_data_s = in_data;
        end
    end

    // Stage register with reset / bubble clearing
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            q_valid <= 1'b0;
            q_wa    <= {AW{1'b0}};
            q_tnew  <= {TNW{1'b0}};
            q_data  <= {DW{1'b0}};
        end else begin
            q_valid <= in_valid;
            q_wa    <= in_wa;
            q_tnew  <= nxt_tnew_s;
            q_data  <= nxt_data_s;
        end
    end

endmodule : wb_stage_reg

// File: rtl/wb_fwd_pipe.sv
// -----------------------------------------------------------------------------
// wb_fwd_pipe
// Write-back select and forwarding pipeline for the 5-stage MIPS core.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : wb_fwd_pipe_if slave -- D producer info, E/M results,
//                D read ports (addr/en/raw GRF data), forwarded operands,
//                stall, GRF write port (driven from the W stage)
// D picks the destination register; E/M/W carry {valid, wa, tnew, data}.
// Each read port takes the youngest matching producer: a ready one forwards,
// a pending one (tnew > 0) on an enabled port stalls D.
// -----------------------------------------------------------------------------
module wb_fwd_pipe
    import wb_fwd_pkg::*;
#(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2,
    parameter int TNW = 2
) (
    input  logic          clk,
    input  logic          reset,
    wb_fwd_pipe_if.slave  bus
);

    logic [AW-1:0]  dest_wa_s;
    logic           dest_we_s;
    logic           stall_s;
    logic [NRD-1:0] stall_v_s;

    logic           e_valid_r, m_valid_r, w_valid_r;
    logic [AW-1:0]  e_wa_r,    m_wa_r,    w_wa_r;
    logic [TNW-1:0] e_tnew_r,  m_tnew_r,  w_tnew_r;
    logic [DW-1:0]  e_data_r,  m_data_r,  w_data_r;

    // Destination register select; r0 or "no write" yields no producer
    always_comb begin
        dest_wa_s = {AW{1'b0}};
        dest_we_s = 1'b0;
        case (wa_sel_e'(bus.id_wa_sel))
            WA_RT:   dest_wa_s = bus.id_rt;
            WA_RD:   dest_wa_s = bus.id_rd;
            WA_RA:   dest_wa_s = AW'(RA_NUM);
            WA_NONE: dest_wa_s = {AW{1'b0}};
            default: dest_wa_s = {AW{1'b0}};
        endcase
        if (dest_wa_s != {AW{1'b0}}) begin
            dest_we_s = 1'b1;
        end else begin
            dest_we_s = 1'b0;
        end
    end

    wb_stage_reg #(.DW(DW), .AW(AW), .TNW(TNW), .RESOLVE(1'b0)) u_e (
        .clk      (clk),
        .reset    (reset),
        .bubble   (stall_s | bus.flush_e),
        .in_valid (bus.id_valid & dest_we_s),
        .in_wa    (dest_wa_s),
        .in_tnew  (bus.id_tnew),
        .in_data  (bus.id_data),
        .res      ({DW{1'b0}}),
        .q_valid  (e_valid_r),
        .q_wa     (e_wa_r),
        .q_tnew   (e_tnew_r),
        .q_data   (e_data_r)
    );

    wb_stage_reg #(.DW(DW), .AW(AW), .TNW(TNW), .RESOLVE(1'b1)) u_m (
        .clk      (clk),
        .reset    (reset),
        .bubble   (1'b0),
        .in_valid (e_valid_r),
        .in_wa    (e_wa_r),
        .in_tnew  (e_tnew_r),
        .in_data  (e_data_r),
        .res      (bus.e_res),
        .q_valid  (m_valid_r),
        .q_wa     (m_wa_r),
        .q_tnew   (m_tnew_r),
        .q_data   (m_data_r)
    );

    wb_stage_reg #(.DW(DW), .AW(AW), .TNW(TNW), .RESOLVE(1'b1)) u_w (
        .clk      (clk),
        .reset    (reset),
        .bubble   (1'b0),
        .in_valid (m_valid_r),
        .in_wa    (m_wa_r),
        .in_tnew  (m_tnew_r),
        .in_data  (m_data_r),
        .res      (bus.m_res),
        .q_valid  (w_valid_r),
        .q_wa     (w_wa_r),
        .q_tnew   (w_tnew_r),
        .q_data   (w_data_r)
    );

    wb_fwd_pipe_chk #(.TNW(TNW)) u_chk (
        .clk    (clk),
        .reset  (reset),
        .m_tnew (m_tnew_r)
    );

    // W drives the GRF write port; the write lands at the next edge
    assign bus.grf_we = w_valid_r;
    assign bus.grf_wa = w_wa_r;
    assign bus.grf_wd = w_data_r;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr_s;
        logic          hit_e_s, hit_m_s, hit_w_s;
        logic [1:0]    sel_s;
        logic [DW-1:0] data_s;
        logic          stall_i_s;

        assign addr_s  = bus.rd_addr[i*AW +: AW];
        assign hit_e_s = e_valid_r && (e_wa_r == addr_s) && (addr_s != {AW{1'b0}});
        assign hit_m_s = m_valid_r && (m_wa_r == addr_s) && (addr_s != {AW{1'b0}});
        assign hit_w_s = w_valid_r && (w_wa_r == addr_s) && (addr_s != {AW{1'b0}});

        // Youngest match decides; a pending one is never bypassed by an older one
        always_comb begin
            sel_s     = FWD_GRF;
            data_s    = bus.grf_rdata[i*DW +: DW];
            stall_i_s = 1'b0;
            if (hit_e_s) begin
                sel_s     = FWD_E;
                data_s    = e_data_r;
                stall_i_s = (e_tnew_r != {TNW{1'b0}}) && bus.rd_en[i];
            end else if (hit_m_s) begin
                sel_s     = FWD_M;
                data_s    = m_data_r;
                stall_i_s = (m_tnew_r != {TNW{1'b0}}) && bus.rd_en[i];
            end else if (hit_w_s) begin
                sel_s     = FWD_W;
                data_s    = w_data_r;
                stall_i_s = (w_tnew_r != {TNW{1'b0}}) && bus.rd_en[i];
            end else begin
                sel_s     = FWD_GRF;
                data_s    = bus.grf_rdata[i*DW +: DW];
                stall_i_s = 1'b0;
            end
        end

        assign bus.fwd_sel[i*2 +: 2]   = sel_s;
        assign bus.fwd_data[i*DW +: DW] = data_s;
        assign stall_v_s[i]            = stall_i_s;
    end

    assign stall_s   = |stall_v_s;
    assign bus.stall = stall_s;

endmodule : wb_fwd_pipe
